// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    MARK_X = 2'b01,
    MARK_O = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    PLAYING = 2'b00,
    WIN     = 2'b01,
    DRAW    = 2'b10
  } game_state_t;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_CHECK = 3'd1,
    S_WRITE = 3'd2,
    S_EVAL  = 3'd3,
    S_OVER  = 3'd4
  } fsm_t;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  // Cell indices of every winning line; a line's position here is its win_line code.
  localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };

  localparam logic [3:0] NO_LINE = 4'hF;

endpackage

// File: rtl/ttt_turn_controller_btn_debounce.sv
// Confirm button conditioning: 2-FF synchronizer, stability filter, rise pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic Clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from the held one for the full window.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
        pulse  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe move sequencer: validates moves, writes marks, scores the board,
// alternates players and auto-moves when the turn timer runs out.
module ttt_turn_controller
  import ttt_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 25_000_000,
  parameter int TURN_TIMEOUT_S  = 10,
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic        Clk,
  input  logic        rst,
  input  logic [3:0]  sel_square,
  input  logic        confirm_btn,
  output logic [17:0] board,
  output logic        current_player,
  output logic [1:0]  game_state,
  output logic [1:0]  winner,
  output logic [3:0]  win_line,
  output logic [7:0]  turn_secs_left,
  output logic        move_ok,
  output logic        move_illegal
);

  localparam int TW = $clog2(CLK_FREQ_HZ);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_FREQ_HZ - 1);
  localparam logic [7:0]    SECS_INIT = 8'(TURN_TIMEOUT_S);

  fsm_t          state;
  logic [3:0]    cand;
  logic [TW-1:0] tick;
  logic          press;

  cell_t         cells [NUM_CELLS];
  cell_t         mover;
  logic          win_hit;
  logic [3:0]    win_idx;
  logic          board_full;
  logic [3:0]    first_empty;
  logic          cand_free;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .Clk   (Clk),
    .rst   (rst),
    .raw   (confirm_btn),
    .pulse (press)
  );

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cells
    assign cells[i] = cell_t'(board[2*i +: 2]);
  end

  assign mover = current_player ? MARK_O : MARK_X;

  // Lowest-index line fully held by the mover's mark.
  always_comb begin
    win_hit = 1'b0;
    win_idx = NO_LINE;
    for (int l = NUM_LINES - 1; l >= 0; l--) begin
      if (cells[WIN_LINES[l][0]] == mover && cells[WIN_LINES[l][1]] == mover &&
          cells[WIN_LINES[l][2]] == mover) begin
        win_hit = 1'b1;
        win_idx = 4'(l);
      end
    end
  end

  // Board occupancy: full flag, auto-move target, and candidate legality.
  always_comb begin
    board_full  = 1'b1;
    first_empty = NO_LINE;
    cand_free   = 1'b0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (cells[i] == EMPTY) begin
        board_full  = 1'b0;
        first_empty = 4'(i);
        if (cand == 4'(i)) cand_free = 1'b1;
      end
    end
  end

  // Turn sequencing FSM with its turn timer and board/score registers.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state          <= S_WAIT;
      cand           <= '0;
      tick           <= '0;
      board          <= '0;
      current_player <= 1'b0;
      game_state     <= PLAYING;
      winner         <= EMPTY;
      win_line       <= NO_LINE;
      turn_secs_left <= SECS_INIT;
      move_ok        <= 1'b0;
      move_illegal   <= 1'b0;
    end else begin
      move_ok      <= 1'b0;
      move_illegal <= 1'b0;
      case (state)
        S_WAIT: begin
          if (press) begin
            cand  <= sel_square;
            state <= S_CHECK;
          end else if (turn_secs_left == 8'd0) begin
            cand  <= first_empty;
            state <= S_CHECK;
          end else if (tick == TICK_LAST) begin
            tick           <= '0;
            turn_secs_left <= turn_secs_left - 8'd1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        S_CHECK: begin
          if (cand_free) begin
            state <= S_WRITE;
          end else begin
            move_illegal <= 1'b1;
            state        <= S_WAIT;
          end
        end
        S_WRITE: begin
          for (int i = 0; i < NUM_CELLS; i++) begin
            if (cand == 4'(i)) board[2*i +: 2] <= mover;
          end
          move_ok <= 1'b1;
          state   <= S_EVAL;
        end
        S_EVAL: begin
          if (win_hit) begin
            game_state <= WIN;
            winner     <= mover;
            win_line   <= win_idx;
            state      <= S_OVER;
          end else if (board_full) begin
            game_state <= DRAW;
            state      <= S_OVER;
          end else begin
            current_player <= ~current_player;
            turn_secs_left <= SECS_INIT;
            tick           <= '0;
            state          <= S_WAIT;
          end
        end
        S_OVER: begin
          if (press) begin
            board          <= '0;
            current_player <= 1'b0;
            game_state     <= PLAYING;
            winner         <= EMPTY;
            win_line       <= NO_LINE;
            turn_secs_left <= SECS_INIT;
            tick           <= '0;
            state          <= S_WAIT;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule
